// File: rtl/proc_pkg.sv
// Shared definitions for the multicycle processor front end: word format,
// opcode encodings and fetch-stage state encoding.
package proc_pkg;

  localparam int unsigned WORD_W     = 16;
  localparam int unsigned OP_W       = 3;
  localparam int unsigned REG_W      = 3;
  localparam int unsigned OP_MSB_DEF = 8;
  localparam int unsigned RX_MSB     = 5;
  localparam int unsigned RY_MSB     = 2;

  typedef logic [OP_W-1:0] opcode_t;

  localparam opcode_t OP_ADD = 3'b000;
  localparam opcode_t OP_SUB = 3'b001;
  localparam opcode_t OP_AND = 3'b010;
  localparam opcode_t OP_OR  = 3'b011;
  localparam opcode_t OP_XOR = 3'b100;
  localparam opcode_t OP_LD  = 3'b101;
  localparam opcode_t OP_ST  = 3'b110;
  localparam opcode_t OP_MVI = 3'b111;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_FETCH     = 3'd1,
    S_WAIT      = 3'd2,
    S_ISSUE     = 3'd3,
    S_IMM_FETCH = 3'd4,
    S_IMM_WAIT  = 3'd5,
    S_EXEC      = 3'd6
  } fetch_state_t;

endpackage

// File: rtl/exec_timer.sv
// Saturating EXEC-cycle counter; tc_c flags the cycle whose increment
// would reach TIMEOUT, so the caller can react on that same edge.
module exec_timer #(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tc_c
);

  localparam int unsigned TW = $clog2(TIMEOUT + 1);

  logic [TW-1:0] count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en && (count != TW'(TIMEOUT))) begin
      count <= count + TW'(1);
    end
  end

  assign tc_c = (count == TW'(TIMEOUT - 1));

endmodule

// File: rtl/instr_fetch.sv
// Fetch stage: owns the PC, reads program words, issues them on DIN with a
// one-cycle Run pulse and waits for Done (or a timeout) before advancing.
module instr_fetch
  import proc_pkg::*;
#(
  parameter int unsigned AW       = 8,
  parameter int unsigned RESET_PC = 0,
  parameter int unsigned OP_MSB   = OP_MSB_DEF,
  parameter int unsigned TIMEOUT  = 15
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              Go,
  input  logic [WORD_W-1:0] MemData,
  output logic [AW-1:0]     MemAddr,
  output logic              MemRd,
  output logic [WORD_W-1:0] DIN,
  output logic              Run,
  input  logic              Done,
  output logic [AW-1:0]     PC,
  output logic              Busy,
  output logic              Error
);

  localparam int unsigned OP_LSB = OP_MSB - (OP_W - 1);

  fetch_state_t state;
  logic         done_seen;
  logic         is_mvi;
  logic         go_q;
  logic         done_any_c;
  logic         tmr_clr_c;
  logic         tmr_en_c;
  logic         tmr_tc_c;
  logic [AW-1:0] pc_next_c;

  assign done_any_c = Done | done_seen;
  assign tmr_en_c   = (state == S_EXEC) && !done_any_c;
  assign tmr_clr_c  = (state != S_EXEC) || done_any_c;
  assign pc_next_c  = PC + (is_mvi ? AW'(2) : AW'(1));

  exec_timer #(.TIMEOUT(TIMEOUT)) u_exec_timer (
    .clk  (Clock),
    .rst  (Reset),
    .clr  (tmr_clr_c),
    .en   (tmr_en_c),
    .tc_c (tmr_tc_c)
  );

  // Outputs are set on the edge entering the state that owns them.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state     <= S_IDLE;
      PC        <= AW'(RESET_PC);
      MemAddr   <= AW'(RESET_PC);
      MemRd     <= 1'b0;
      DIN       <= '0;
      Run       <= 1'b0;
      Busy      <= 1'b0;
      Error     <= 1'b0;
      done_seen <= 1'b0;
      is_mvi    <= 1'b0;
      go_q      <= 1'b0;
    end else begin
      go_q  <= Go;
      Run   <= 1'b0;
      MemRd <= 1'b0;
      if (Go && !go_q) begin
        Error <= 1'b0;
      end
      case (state)
        S_IDLE: begin
          if (Go) begin
            state   <= S_FETCH;
            MemAddr <= PC;
            MemRd   <= 1'b1;
            Busy    <= 1'b1;
          end
        end
        S_FETCH: begin
          state <= S_WAIT;
        end
        S_WAIT: begin
          DIN   <= MemData;
          Run   <= 1'b1;
          state <= S_ISSUE;
        end
        S_ISSUE: begin
          done_seen <= done_seen | Done;
          is_mvi    <= (DIN[OP_MSB:OP_LSB] == OP_MVI);
          if (DIN[OP_MSB:OP_LSB] == OP_MVI) begin
            state   <= S_IMM_FETCH;
            MemAddr <= PC + AW'(1);
            MemRd   <= 1'b1;
          end else begin
            state <= S_EXEC;
          end
        end
        S_IMM_FETCH: begin
          done_seen <= done_seen | Done;
          state     <= S_IMM_WAIT;
        end
        S_IMM_WAIT: begin
          done_seen <= done_seen | Done;
          DIN       <= MemData;
          state     <= S_EXEC;
        end
        S_EXEC: begin
          if (done_any_c) begin
            PC        <= pc_next_c;
            done_seen <= 1'b0;
            if (Go) begin
              state   <= S_FETCH;
              MemAddr <= pc_next_c;
              MemRd   <= 1'b1;
            end else begin
              state <= S_IDLE;
              Busy  <= 1'b0;
            end
          end else if (tmr_tc_c) begin
            Error     <= 1'b1;
            done_seen <= 1'b0;
            state     <= S_IDLE;
            Busy      <= 1'b0;
          end
        end
        default: begin
          state <= S_IDLE;
          Busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: synchronous program memory model, hand-computed
// expectations for latency, mvi immediates, PC wrap, early Done, timeout and reset.
module tb_instr_fetch;

  logic        Clock;
  logic        Reset;
  logic        Go;
  logic [15:0] MemData;
  logic [7:0]  MemAddr;
  logic        MemRd;
  logic [15:0] DIN;
  logic        Run;
  logic        Done;
  logic [7:0]  PC;
  logic        Busy;
  logic        Error;

  logic [15:0] mem [256];
  int          errors = 0;
  int          checks = 0;
  int          n;

  instr_fetch #(.AW(8), .RESET_PC(0), .OP_MSB(8), .TIMEOUT(15)) dut (
    .Clock   (Clock),
    .Reset   (Reset),
    .Go      (Go),
    .MemData (MemData),
    .MemAddr (MemAddr),
    .MemRd   (MemRd),
    .DIN     (DIN),
    .Run     (Run),
    .Done    (Done),
    .PC      (PC),
    .Busy    (Busy),
    .Error   (Error)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  always @(posedge Clock) begin
    if (MemRd) MemData <= mem[MemAddr];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge Clock);
    #1;
  endtask

  // Steps until Run is seen, bounded; returns the number of edges taken.
  task automatic wait_run(output int cnt);
    cnt = 0;
    do begin
      step();
      cnt++;
    end while (!Run && cnt < 20);
    if (!Run) check("run_timeout", 32'(Run), 32'd1);
  endtask

  // One non-mvi instruction with Done on its first EXEC cycle; Go left high.
  task automatic exec_plain();
    int c;
    wait_run(c);
    step();
    Done = 1'b1;
    step();
    Done = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 16'h0008;
    mem[1] = 16'h0048;
    mem[4] = 16'h01C0;
    mem[5] = 16'h00AB;
    MemData = '0;
    Reset = 1'b1;
    Go    = 1'b0;
    Done  = 1'b0;
    #1;
    check("rst_pc", 32'(PC), 32'h0);
    check("rst_memaddr", 32'(MemAddr), 32'h0);
    check("rst_memrd", 32'(MemRd), 32'h0);
    check("rst_din", 32'(DIN), 32'h0);
    check("rst_run", 32'(Run), 32'h0);
    check("rst_busy", 32'(Busy), 32'h0);
    check("rst_error", 32'(Error), 32'h0);
    step();
    step();
    Reset = 1'b0;

    // 1: first fetch latency, plain add, back-to-back, Go dropped mid-instruction
    Go = 1'b1;
    wait_run(n);
    check("t1_latency", 32'(n), 32'd3);
    check("t1_din", 32'(DIN), 32'h0008);
    step();
    check("t1_run_pulse", 32'(Run), 32'd0);
    step();
    Done = 1'b1;
    step();
    Done = 1'b0;
    check("t1_pc", 32'(PC), 32'h1);
    check("t1_memaddr", 32'(MemAddr), 32'h1);
    check("t1_memrd", 32'(MemRd), 32'h1);
    Go = 1'b0;
    wait_run(n);
    check("t1_b2b_lat", 32'(n), 32'd2);
    check("t1_din2", 32'(DIN), 32'h0048);
    Done = 1'b1;
    step();
    Done = 1'b0;
    step();
    check("t1_stop_pc", 32'(PC), 32'h2);
    check("t1_stop_busy", 32'(Busy), 32'h0);

    // 2: mvi with immediate at PC=4
    Go = 1'b1;
    exec_plain();
    exec_plain();
    wait_run(n);
    check("t2_lat", 32'(n), 32'd2);
    check("t2_pc", 32'(PC), 32'h4);
    check("t2_din_op", 32'(DIN), 32'h01C0);
    step();
    check("t2_imm_addr", 32'(MemAddr), 32'h5);
    check("t2_imm_rd", 32'(MemRd), 32'h1);
    step();
    step();
    check("t2_din_imm", 32'(DIN), 32'h00AB);
    Go = 1'b0;
    Done = 1'b1;
    step();
    Done = 1'b0;
    check("t2_pc_after", 32'(PC), 32'h6);

    // 3: mvi at PC=255 wraps the immediate read to address 0
    mem[0]   = 16'h1234;
    mem[255] = 16'h01C0;
    Go = 1'b1;
    for (int i = 6; i < 255; i++) exec_plain();
    check("t3_pc_255", 32'(PC), 32'hFF);
    wait_run(n);
    check("t3_din_op", 32'(DIN), 32'h01C0);
    step();
    check("t3_imm_addr", 32'(MemAddr), 32'h0);
    step();
    step();
    check("t3_din_imm", 32'(DIN), 32'h1234);
    Go = 1'b0;
    Done = 1'b1;
    step();
    Done = 1'b0;
    check("t3_pc_wrap", 32'(PC), 32'h1);

    // 4: Done during ISSUE of an mvi is remembered
    mem[1] = 16'h01C0;
    mem[2] = 16'h0055;
    Go = 1'b1;
    wait_run(n);
    Done = 1'b1;
    step();
    Done = 1'b0;
    step();
    step();
    check("t4_din_imm", 32'(DIN), 32'h0055);
    Go = 1'b0;
    step();
    check("t4_pc", 32'(PC), 32'h3);
    check("t4_busy", 32'(Busy), 32'h0);
    check("t4_error", 32'(Error), 32'h0);
    Done = 1'b1;
    step();
    step();
    Done = 1'b0;
    check("t4_idle_done_busy", 32'(Busy), 32'h0);
    check("t4_idle_done_pc", 32'(PC), 32'h3);

    // 5: Done never arrives -> Error after 15 EXEC cycles, Go edge clears it
    Go = 1'b1;
    wait_run(n);
    Go = 1'b0;
    for (int i = 0; i < 15; i++) step();
    check("t5_no_err_yet", 32'(Error), 32'h0);
    check("t5_still_busy", 32'(Busy), 32'h1);
    step();
    check("t5_error", 32'(Error), 32'h1);
    check("t5_idle", 32'(Busy), 32'h0);
    check("t5_pc_hold", 32'(PC), 32'h3);
    step();
    step();
    check("t5_error_sticky", 32'(Error), 32'h1);
    Go = 1'b1;
    step();
    check("t5_error_clr", 32'(Error), 32'h0);
    check("t5_refetch_addr", 32'(MemAddr), 32'h3);
    check("t5_refetch_rd", 32'(MemRd), 32'h1);
    wait_run(n);
    check("t5_refetch_lat", 32'(n), 32'd2);
    step();
    Done = 1'b1;
    Go = 1'b0;
    step();
    Done = 1'b0;
    check("t5_pc_after", 32'(PC), 32'h4);

    // 6: asynchronous reset during IMM_WAIT
    Go = 1'b1;
    wait_run(n);
    step();
    step();
    Reset = 1'b1;
    #1;
    check("t6_pc", 32'(PC), 32'h0);
    check("t6_memaddr", 32'(MemAddr), 32'h0);
    check("t6_memrd", 32'(MemRd), 32'h0);
    check("t6_din", 32'(DIN), 32'h0);
    check("t6_run", 32'(Run), 32'h0);
    check("t6_busy", 32'(Busy), 32'h0);
    Go = 1'b0;
    step();
    Reset = 1'b0;
    step();
    Go = 1'b1;
    wait_run(n);
    check("t6_restart_lat", 32'(n), 32'd3);
    check("t6_restart_din", 32'(DIN), 32'h1234);
    Go = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
